// File: rtl/mio_responder_if.sv
// rtl/mio_responder_if.sv - CPU-side memory/IO handshake bundle for mio_responder
interface mio_responder_if;
  logic        mem_r;
  logic        mem_w;
  logic        cpu_mio;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        mio_ready;

  modport master (
    output mem_r, mem_w, cpu_mio, addr, wdata,
    input  rdata, mio_ready
  );

  modport slave (
    input  mem_r, mem_w, cpu_mio, addr, wdata,
    output rdata, mio_ready
  );
endinterface

// File: rtl/mio_responder.sv
// rtl/mio_responder.sv - memory/IO responder: RAM with wait states, LED/switch/cycle-counter registers
// Optional macro MIO_BUSERR_EN: sticky bus_err on unmapped accesses and switch writes.
module mio_responder #(
  parameter int RAM_AW  = 10,
  parameter int RAM_LAT = 2,
  parameter int LED_W   = 16,
  parameter int SW_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  mio_responder_if.slave    bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic              bus_err
);
  localparam logic [31:0] LED_ADDR  = 32'hFFFF_FF00;
  localparam logic [31:0] SW_ADDR   = 32'hFFFF_FF04;
  localparam logic [31:0] CNT_ADDR  = 32'hFFFF_FF08;
  localparam logic [3:0]  WAIT_INIT = 4'(RAM_LAT - 1);

  typedef enum logic [1:0] {IDLE, RAM_WAIT, DONE} state_t;
  state_t state, next_state;

  logic [3:0]      wait_cnt;
  logic            wr_q;
  logic [31:0]     cyc_cnt;
  logic [SW_W-1:0] sw_meta, sw_sync;
  logic [31:0]     rdata_q;
  logic            ready_c, we_c;
  logic            accept, is_wr, hit_ram, hit_led, hit_sw, hit_cnt;
  logic            unused_addr_lsbs;

  assign accept  = (state == IDLE) && (bus.mem_r || bus.mem_w) && bus.cpu_mio;
  assign is_wr   = bus.mem_w;
  assign hit_ram = (bus.addr[31:RAM_AW+2] == '0);
  assign hit_led = (bus.addr[31:2] == LED_ADDR[31:2]);
  assign hit_sw  = (bus.addr[31:2] == SW_ADDR[31:2]);
  assign hit_cnt = (bus.addr[31:2] == CNT_ADDR[31:2]);
  assign unused_addr_lsbs = ^bus.addr[1:0];

  assign bus.rdata     = rdata_q;
  assign bus.mio_ready = ready_c;
  assign ram_we        = we_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready_c    = 1'b0;
    we_c       = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = hit_ram ? RAM_WAIT : DONE;
      end
      RAM_WAIT: begin
        // The counter still holds its load value only in the first wait cycle.
        we_c = wr_q && (wait_cnt == WAIT_INIT);
        if (wait_cnt == 4'd0) next_state = DONE;
      end
      DONE: begin
        ready_c    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      wr_q      <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 32'd0;
      rdata_q   <= 32'd0;
      led       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wr_q <= is_wr;
            if (hit_ram) begin
              ram_addr  <= bus.addr[RAM_AW+1:2];
              ram_wdata <= bus.wdata;
              wait_cnt  <= WAIT_INIT;
            end else if (is_wr) begin
              if (hit_led) led <= bus.wdata[LED_W-1:0];
            end else if (hit_led) begin
              rdata_q <= 32'(led);
            end else if (hit_sw) begin
              rdata_q <= 32'(sw_sync);
            end else if (hit_cnt) begin
              // Report the count as it stands after this edge's increment.
              rdata_q <= cyc_cnt + 32'd1;
            end else begin
              rdata_q <= 32'd0;
            end
          end
        end
        RAM_WAIT: begin
          if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
          else if (!wr_q)       rdata_q  <= ram_rdata;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
      cyc_cnt <= 32'd0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
      if (accept && hit_cnt && is_wr) cyc_cnt <= 32'd0;
      else                            cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

`ifdef MIO_BUSERR_EN
  logic hit_none;
  assign hit_none = !(hit_ram || hit_led || hit_sw || hit_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       bus_err <= 1'b0;
    else if (accept && (hit_none || (hit_sw && is_wr))) bus_err <= 1'b1;
  end
`else
  assign bus_err = 1'b0;
`endif
endmodule

// File: tb/tb_mio_responder.sv
// tb/tb_mio_responder.sv - randomized scoreboard bench for mio_responder
module tb_mio_responder;
  localparam int RAM_AW  = 10;
  localparam int RAM_LAT = 2;
  localparam int LED_W   = 16;
  localparam int SW_W    = 16;
  localparam logic [31:0] LED_A = 32'hFFFF_FF00;
  localparam logic [31:0] SW_A  = 32'hFFFF_FF04;
  localparam logic [31:0] CNT_A = 32'hFFFF_FF08;
`ifdef MIO_BUSERR_EN
  localparam bit BUSERR_EN = 1'b1;
`else
  localparam bit BUSERR_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = 32'd0;
  logic [SW_W-1:0]   sw;
  logic [LED_W-1:0]  led;
  logic              bus_err;

  mio_responder_if bus();

  mio_responder #(.RAM_AW(RAM_AW), .RAM_LAT(RAM_LAT), .LED_W(LED_W), .SW_W(SW_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .sw(sw), .led(led), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Board RAM seen by the DUT: synchronous read, one-cycle data latency.
  logic [31:0] ram [0:1023];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  typedef struct {
    logic [31:0] rdata;
    bit          chk;
    int unsigned due;
    bit          berr;
    logic [15:0] led;
    bit          is_ram;
    logic [9:0]  ridx;
  } exp_t;
  typedef struct {
    logic [9:0]  idx;
    logic [31:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  logic [31:0] ref_mem [0:1023];
  logic [15:0] ref_led;
  logic [15:0] ref_sw;
  int unsigned cnt_base;
  bit          ref_berr;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Reference model: decode by address map, update shadow state, queue the expected completion.
  task automatic model(input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    wr_t  w;
    bit   berr_set;
    berr_set = 1'b0;
    e.chk = !wr; e.rdata = 32'd0; e.is_ram = 1'b0; e.ridx = 10'd0;
    if (a < 32'd4096) begin
      e.is_ram = 1'b1;
      e.ridx   = a[11:2];
      e.due    = cyc + 32'(RAM_LAT) + 1;
      if (wr) begin
        ref_mem[a[11:2]] = d;
        w.idx = a[11:2]; w.data = d;
        wr_q.push_back(w);
      end else begin
        e.rdata = ref_mem[a[11:2]];
      end
    end else begin
      e.due = cyc + 1;
      if (a[31:2] == LED_A[31:2]) begin
        if (wr) ref_led = d[15:0];
        else    e.rdata = {16'd0, ref_led};
      end else if (a[31:2] == SW_A[31:2]) begin
        if (wr) berr_set = 1'b1;
        else    e.rdata = {16'd0, ref_sw};
      end else if (a[31:2] == CNT_A[31:2]) begin
        if (wr) cnt_base = cyc + 1;
        else    e.rdata = cyc + 1 - cnt_base;
      end else begin
        berr_set = 1'b1;
      end
    end
    if (berr_set && BUSERR_EN) ref_berr = 1'b1;
    e.berr = ref_berr;
    e.led  = ref_led;
    exp_q.push_back(e);
  endtask

  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int k;
    @(negedge clk);
    bus.mem_r = rd; bus.mem_w = wr; bus.cpu_mio = 1'b1; bus.addr = a; bus.wdata = d;
    model(wr, a, d);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus.cpu_mio = 1'($urandom_range(0, 1));
        bus.mem_r   = 1'($urandom_range(0, 1));
        bus.mem_w   = 1'($urandom_range(0, 1));
        bus.addr    = $urandom;
        bus.wdata   = $urandom;
      end
    end while (!bus.mio_ready && k < 40);
    if (!bus.mio_ready) check("ready_timeout", 32'd0, 32'd1);
    bus.cpu_mio = 1'b0; bus.mem_r = 1'b0; bus.mem_w = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    wr_t  w;
    if (!reset) begin
      if (bus.mio_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_ready", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ready_cycle", cyc, e.due);
          if (e.chk) check("rdata", bus.rdata, e.rdata);
          check("led", 32'(led), 32'(e.led));
          check("bus_err", 32'(bus_err), 32'(e.berr));
          if (e.is_ram) check("ram_addr_done", 32'(ram_addr), 32'(e.ridx));
        end
      end
      if (ram_we) begin
        if (wr_q.size() == 0) begin
          check("spurious_ram_we", 32'd1, 32'd0);
        end else begin
          w = wr_q.pop_front();
          check("ram_we_addr", 32'(ram_addr), 32'(w.idx));
          check("ram_we_data", ram_wdata, w.data);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdata"}, bus.rdata, 32'd0);
    check({tag, "_ready"}, 32'(bus.mio_ready), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    check({tag, "_led"}, 32'(led), 32'd0);
    check({tag, "_bus_err"}, 32'(bus_err), 32'd0);
  endtask

  initial begin : stim
    int          sel;
    bit          rd, wr;
    logic [31:0] a;
    bus.mem_r = 1'b0; bus.mem_w = 1'b0; bus.cpu_mio = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
    sw = '0; ref_sw = 16'd0; ref_led = 16'd0; ref_berr = 1'b0; cnt_base = 0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     <= init_word(i);
      ref_mem[i]  = init_word(i);
    end
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    cnt_base = cyc;

    do_req(1'b1, 1'b0, 32'h0000_0010, 32'd0);
    do_req(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    do_req(1'b0, 1'b1, LED_A, 32'h0000_A5A5);
    do_req(1'b1, 1'b0, LED_A, 32'd0);
    @(negedge clk);
    sw = 16'h00F0; ref_sw = 16'h00F0;
    repeat (3) @(negedge clk);
    do_req(1'b1, 1'b0, SW_A, 32'd0);
    do_req(1'b0, 1'b1, CNT_A, 32'hFFFF_FFFF);
    do_req(1'b1, 1'b0, CNT_A, 32'd0);
    do_req(1'b1, 1'b0, 32'h8000_0000, 32'd0);
    do_req(1'b1, 1'b0, 32'h0000_0020, 32'd0);

    // Reset in the middle of a RAM read: nothing completes, everything returns to reset values.
    @(negedge clk);
    bus.mem_r = 1'b1; bus.cpu_mio = 1'b1; bus.addr = 32'h0000_0040;
    @(negedge clk);
    bus.mem_r = 1'b0; bus.cpu_mio = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    check("midreset_no_ready", 32'(bus.mio_ready), 32'd0);
    reset = 1'b0;
    cnt_base = cyc; ref_led = 16'd0; ref_berr = 1'b0;
    do_req(1'b1, 1'b0, 32'h0000_0040, 32'd0);
    do_req(1'b1, 1'b0, CNT_A, 32'd0);

    for (int i = 0; i < 160; i++) begin
      sel = int'($urandom_range(0, 9));
      wr  = 1'($urandom_range(0, 1));
      rd  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      case (sel)
        0, 1, 2, 3, 4: a = 32'($urandom_range(0, 127));
        5:             a = LED_A | 32'($urandom_range(0, 3));
        6:             a = SW_A;
        7:             a = CNT_A;
        8:             a = (i % 2 == 0) ? 32'hFFFF_FF0C : 32'h0000_1000 + 32'($urandom_range(0, 32'h7FFF_0000));
        default:       a = 32'd0;
      endcase
      if (sel == 9) begin
        @(negedge clk);
        sw = 16'($urandom); ref_sw = sw;
        repeat (3) @(negedge clk);
      end else begin
        do_req(rd, wr, a, $urandom);
      end
    end

    repeat (5) @(negedge clk);
    check("pending_ready", 32'(exp_q.size()), 32'd0);
    check("pending_ram_we", 32'(wr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
